// File: rtl/multicycle_control_unit_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit_if
// Purpose : groups the instruction-memory handshake, the data-memory handshake
//           and the datapath control/status signals of the multi-cycle control
//           unit into one bundle.
// Signals : start, opcode, if_ack, mem_ready      (into the control unit)
//           if_req, ir_load, pc_inc, pc_load,
//           reg_write, mem_read, mem_write,
//           alu_op, halted, err, retired          (out of the control unit)
// Modports: master - the control unit
//           slave  - the datapath / memory side
// -----------------------------------------------------------------------------
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 16
);
  logic                start;
  logic [OPCODE_W-1:0] opcode;
  logic                if_ack;
  logic                mem_ready;
  logic                if_req;
  logic                ir_load;
  logic                pc_inc;
  logic                pc_load;
  logic                reg_write;
  logic                mem_read;
  logic                mem_write;
  logic [ALUOP_W-1:0]  alu_op;
  logic                halted;
  logic                err;
  logic [CNT_W-1:0]    retired;

  modport master (
    input  start, opcode, if_ack, mem_ready,
    output if_req, ir_load, pc_inc, pc_load, reg_write, mem_read, mem_write,
           alu_op, halted, err, retired
  );

  modport slave (
    output start, opcode, if_ack, mem_ready,
    input  if_req, ir_load, pc_inc, pc_load, reg_write, mem_read, mem_write,
           alu_op, halted, err, retired
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
// Purpose : sequences each instruction through FETCH, DECODE, EXEC, MEM and WB,
//           handshaking with instruction and data memory, driving PC, ALU and
//           register-file controls, stopping on HALT and counting retired
//           instructions.
// Ports   : clk   - clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - multicycle_control_unit_if.master (handshakes + controls)
// Options : CU_MEM_TIMEOUT_EN - when defined, a MEM wait of TIMEOUT_CYC cycles
//           without mem_ready sends the unit to a sticky ERROR state (err=1).
//           When undefined, MEM waits forever and err is tied low.
// Opcodes : 0 ADD, 1 SUB, 2 LOAD, 3 STORE, 4 JUMP, 5 HALT, others NOP.
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int OPCODE_W    = 4,
  parameter int ALUOP_W     = 2,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  multicycle_control_unit_if.master bus
);

  // Elaboration-time guard on the parameter ranges the decode relies on.
  if (OPCODE_W < 4 || ALUOP_W < 2 || CNT_W < 1 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("multicycle_control_unit: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [OPCODE_W-1:0] r_op_q;
  logic [CNT_W-1:0]    r_retired;
  logic                w_retire;

  logic w_is_add, w_is_sub, w_is_load, w_is_store, w_is_jump, w_is_halt;
  logic [ALUOP_W-1:0] w_alu_sel;

  logic               w_if_req, w_ir_load, w_pc_inc, w_pc_load, w_reg_write;
  logic               w_mem_read, w_mem_write, w_halted, w_err;
  logic [ALUOP_W-1:0] w_alu_op;

  assign w_is_add   = (r_op_q == OPCODE_W'(4'd0));
  assign w_is_sub   = (r_op_q == OPCODE_W'(4'd1));
  assign w_is_load  = (r_op_q == OPCODE_W'(4'd2));
  assign w_is_store = (r_op_q == OPCODE_W'(4'd3));
  assign w_is_jump  = (r_op_q == OPCODE_W'(4'd4));
  assign w_is_halt  = (r_op_q == OPCODE_W'(4'd5));

  // ALU code shared by EXEC and WB so the result stays stable while it is written.
  assign w_alu_sel = w_is_add ? ALUOP_W'(2'b10) :
                     w_is_sub ? ALUOP_W'(2'b11) : ALUOP_W'(2'b00);

`ifdef CU_MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              w_timeout;

  // The last no-ready cycle is the one that would bring the count to TIMEOUT_CYC.
  assign w_timeout = (r_wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));

  // MEM wait counter: zero outside MEM, so it is cleared on every MEM entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_state != S_MEM) begin
      r_wait_cnt <= '0;
    end else if (!bus.mem_ready) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end else begin
      r_wait_cnt <= r_wait_cnt;
    end
  end
`endif

  // State register and latched opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op_q  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_FETCH && bus.if_ack) begin
        r_op_q <= bus.opcode;
      end else begin
        r_op_q <= r_op_q;
      end
    end
  end

  // Next-state logic; w_retire marks the final cycle of every retiring instruction.
  always_comb begin
    w_state_nxt = r_state;
    w_retire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_FETCH;
        else           w_state_nxt = S_IDLE;
      end
      S_FETCH: begin
        if (bus.if_ack) w_state_nxt = S_DECODE;
        else            w_state_nxt = S_FETCH;
      end
      S_DECODE: begin
        if (w_is_add || w_is_sub || w_is_jump) begin
          w_state_nxt = S_EXEC;
        end else if (w_is_load || w_is_store) begin
          w_state_nxt = S_MEM;
        end else if (w_is_halt) begin
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt = S_FETCH;
          w_retire    = 1'b1;
        end
      end
      S_EXEC: begin
        if (w_is_jump) begin
          w_state_nxt = S_FETCH;
          w_retire    = 1'b1;
        end else if (w_is_add || w_is_sub) begin
          w_state_nxt = S_WB;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_MEM: begin
        // mem_ready takes priority over a timeout in the same cycle.
        if (bus.mem_ready) begin
          if (w_is_load) begin
            w_state_nxt = S_WB;
          end else begin
            w_state_nxt = S_FETCH;
            w_retire    = 1'b1;
          end
        end
`ifdef CU_MEM_TIMEOUT_EN
        else if (w_timeout) begin
          w_state_nxt = S_ERROR;
        end
`endif
        else begin
          w_state_nxt = S_MEM;
        end
      end
      S_WB: begin
        w_state_nxt = S_FETCH;
        w_retire    = 1'b1;
      end
      S_HALT:  w_state_nxt = S_HALT;
      S_ERROR: w_state_nxt = S_ERROR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the registered state; ir_load alone follows if_ack directly.
  always_comb begin
    w_if_req    = 1'b0;
    w_ir_load   = 1'b0;
    w_pc_inc    = 1'b0;
    w_pc_load   = 1'b0;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_alu_op    = '0;
    w_halted    = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: w_if_req = 1'b0;
      S_FETCH: begin
        w_if_req  = 1'b1;
        w_ir_load = bus.if_ack;
      end
      S_DECODE: w_pc_inc = 1'b1;
      S_EXEC: begin
        w_alu_op  = w_alu_sel;
        w_pc_load = w_is_jump;
      end
      S_MEM: begin
        w_mem_read  = w_is_load;
        w_mem_write = w_is_store;
      end
      S_WB: begin
        w_reg_write = 1'b1;
        w_alu_op    = w_alu_sel;
      end
      S_HALT: w_halted = 1'b1;
`ifdef CU_MEM_TIMEOUT_EN
      S_ERROR: w_err = 1'b1;
`else
      S_ERROR: w_err = 1'b0;
`endif
      default: w_err = 1'b0;
    endcase
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
    end else begin
      r_retired <= r_retired;
    end
  end

  assign bus.if_req    = w_if_req;
  assign bus.ir_load   = w_ir_load;
  assign bus.pc_inc    = w_pc_inc;
  assign bus.pc_load   = w_pc_load;
  assign bus.reg_write = w_reg_write;
  assign bus.mem_read  = w_mem_read;
  assign bus.mem_write = w_mem_write;
  assign bus.alu_op    = w_alu_op;
  assign bus.halted    = w_halted;
  assign bus.err       = w_err;
  assign bus.retired   = r_retired;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
// Directed per-cycle stimulus; each driven cycle pushes its hand-computed
// expected control vector and retired count into a queue, and a monitor on the
// falling edge pops and compares. CNT_W=4 so the counter wrap is reachable.
// Control vector bits: {if_req, ir_load, pc_inc, pc_load, reg_write, mem_read,
//                       mem_write, alu_op[1:0], halted, err}
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;
  localparam int OPCODE_W = 4;
  localparam int ALUOP_W  = 2;
  localparam int CNT_W    = 4;

  localparam logic [10:0] C_IDLE  = 11'b000_0000_0000;
  localparam logic [10:0] C_FREQ  = 11'b100_0000_0000;
  localparam logic [10:0] C_FACK  = 11'b110_0000_0000;
  localparam logic [10:0] C_DEC   = 11'b001_0000_0000;
  localparam logic [10:0] C_ADD   = 11'b000_0000_1000;
  localparam logic [10:0] C_SUB   = 11'b000_0000_1100;
  localparam logic [10:0] C_WBADD = 11'b000_0100_1000;
  localparam logic [10:0] C_WBSUB = 11'b000_0100_1100;
  localparam logic [10:0] C_WBLD  = 11'b000_0100_0000;
  localparam logic [10:0] C_JMP   = 11'b000_1000_0000;
  localparam logic [10:0] C_MR    = 11'b000_0010_0000;
  localparam logic [10:0] C_MW    = 11'b000_0001_0000;
  localparam logic [10:0] C_HALT  = 11'b000_0000_0010;
  localparam logic [10:0] C_ERR   = 11'b000_0000_0001;

  typedef struct {
    logic [10:0]      ctrl;
    logic [CNT_W-1:0] ret;
    string            nm;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [10:0] mon_act;
  int n_tests;
  int n_fail;

  multicycle_control_unit_if #(.OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

  multicycle_control_unit #(
    .OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W), .TIMEOUT_CYC(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle of stimulus with its expected outputs.
  task automatic cyc(input logic rn, input logic st, input logic [3:0] op,
                     input logic ack, input logic rdy, input logic [10:0] ec,
                     input logic [CNT_W-1:0] er, input string nm);
    exp_t e;
    rst_n         = rn;
    bus.start     = st;
    bus.opcode    = op;
    bus.if_ack    = ack;
    bus.mem_ready = rdy;
    e.ctrl = ec;
    e.ret  = er;
    e.nm   = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares DUT outputs with the queued expectation each falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_act = {bus.if_req, bus.ir_load, bus.pc_inc, bus.pc_load, bus.reg_write,
                 bus.mem_read, bus.mem_write, bus.alu_op, bus.halted, bus.err};
      n_tests++;
      if (mon_act !== mon_e.ctrl || bus.retired !== mon_e.ret) begin
        n_fail++;
        $display("FAIL %s: got ctrl=%b retired=%0d, expected ctrl=%b retired=%0d",
                 mon_e.nm, mon_act, bus.retired, mon_e.ctrl, mon_e.ret);
      end
    end
  end

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.opcode    = 4'd0;
    bus.if_ack    = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset state, with start already high.
    cyc(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, C_IDLE, 4'd0, "reset");
    cyc(1'b1, 1'b1, 4'd0, 1'b0, 1'b1, C_IDLE, 4'd0, "idle");

    // ADD, zero-wait memory: 4 cycles.
    cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, C_FACK,  4'd0, "add_fetch");
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, C_DEC,   4'd0, "add_dec");
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, C_ADD,   4'd0, "add_exec");
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, C_WBADD, 4'd0, "add_wb");

    // LOAD, mem_ready delayed 3 cycles (mem_ready in FETCH is ignored).
    cyc(1'b1, 1'b0, 4'd2, 1'b1, 1'b1, C_FACK, 4'd1, "ld_fetch");
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, C_DEC,  4'd1, "ld_dec");
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, C_MR, 4'd1, "ld_mem_wait");
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, C_MR,   4'd1, "ld_mem_ready");
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, C_WBLD, 4'd1, "ld_wb");

    // STORE with one wait, then JUMP back-to-back.
    cyc(1'b1, 1'b0, 4'd3, 1'b1, 1'b0, C_FACK, 4'd2, "st_fetch");
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, C_DEC,  4'd2, "st_dec");
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, C_MW,   4'd2, "st_mem_wait");
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, C_MW,   4'd2, "st_mem_ready");
    cyc(1'b1, 1'b0, 4'd4, 1'b1, 1'b0, C_FACK, 4'd3, "jmp_fetch");
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, C_DEC,  4'd3, "jmp_dec");
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, C_JMP,  4'd3, "jmp_exec");

    // SUB, then an undefined opcode as NOP.
    cyc(1'b1, 1'b0, 4'd1, 1'b1, 1'b0, C_FACK,  4'd4, "sub_fetch");
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, C_DEC,   4'd4, "sub_dec");
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, C_SUB,   4'd4, "sub_exec");
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, C_WBSUB, 4'd4, "sub_wb");
    cyc(1'b1, 1'b0, 4'd9, 1'b1, 1'b0, C_FACK,  4'd5, "nop_fetch");
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, C_DEC,   4'd5, "nop_dec");

    // if_ack withheld 5 cycles; start outside IDLE has no effect.
    for (int i = 0; i < 5; i++)
      cyc(1'b1, (i == 0), 4'd5, 1'b0, 1'b0, C_FREQ, 4'd6, "fetch_wait");

    // HALT: sticky, start ignored, retired frozen.
    cyc(1'b1, 1'b0, 4'd5, 1'b1, 1'b0, C_FACK, 4'd6, "halt_fetch");
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, C_DEC,  4'd6, "halt_dec");
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b1, 4'd0, 1'b1, 1'b1, C_HALT, 4'd6, "halted");
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, C_IDLE, 4'd0, "halt_reset");

    // Reset dropped during a LOAD MEM wait aborts it.
    cyc(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, C_IDLE, 4'd0, "idle2");
    cyc(1'b1, 1'b0, 4'd2, 1'b1, 1'b0, C_FACK, 4'd0, "ld2_fetch");
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, C_DEC,  4'd0, "ld2_dec");
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, C_MR,   4'd0, "ld2_mem_wait");
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, C_IDLE, 4'd0, "mem_reset");
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, C_IDLE, 4'd0, "mem_reset_hold");
    cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, C_IDLE, 4'd0, "idle_after_reset");
    cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, C_IDLE, 4'd0, "idle_stays");

    // Retired counter wrap: 17 NOPs with CNT_W=4.
    cyc(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, C_IDLE, 4'd0, "idle3");
    for (int i = 0; i < 17; i++) begin
      cyc(1'b1, 1'b0, 4'd15, 1'b1, 1'b0, C_FACK, CNT_W'(i), "wrap_fetch");
      cyc(1'b1, 1'b0, 4'd0,  1'b0, 1'b0, C_DEC,  CNT_W'(i), "wrap_dec");
    end
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, C_FREQ, 4'd1, "wrap_done");

`ifdef CU_MEM_TIMEOUT_EN
    // Timeout: mem_ready never comes, ERROR after 4 MEM cycles and held.
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, C_IDLE, 4'd0, "to_reset");
    cyc(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, C_IDLE, 4'd0, "to_idle");
    cyc(1'b1, 1'b0, 4'd2, 1'b1, 1'b0, C_FACK, 4'd0, "to_fetch");
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, C_DEC,  4'd0, "to_dec");
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, C_MR, 4'd0, "to_mem_wait");
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, 4'd0, 1'b1, 1'b1, C_ERR, 4'd0, "to_error");
    // mem_ready on the 4th MEM cycle wins over the timeout.
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, C_IDLE, 4'd0, "to2_reset");
    cyc(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, C_IDLE, 4'd0, "to2_idle");
    cyc(1'b1, 1'b0, 4'd2, 1'b1, 1'b0, C_FACK, 4'd0, "to2_fetch");
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, C_DEC,  4'd0, "to2_dec");
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, C_MR, 4'd0, "to2_mem_wait");
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, C_MR,   4'd0, "to2_mem_ready");
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, C_WBLD, 4'd0, "to2_wb");
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, C_FREQ, 4'd1, "to2_done");
`endif

    // Let the monitor drain, bounded.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
